// File: rtl/hash_compare_pipe_pkg.sv
// hash_compare_pipe_pkg
//   Shared constants and types for the hash compare pipeline:
//   IV constant, hash width, maximum lane count, hit FSM state type
//   and a byte-reversal helper used by every lane.
package hash_compare_pipe_pkg;

  localparam int HASH_W    = 64;
  localparam int MAX_LANES = 8;

  localparam logic [HASH_W-1:0] IV = 64'h6a09e667f2bdc928;

  typedef enum logic {
    HIT_EMPTY = 1'b0,
    HIT_FULL  = 1'b1
  } hit_state_t;

  // Byte at x[7:0] lands in the result's top byte, x[63:56] in its bottom byte.
  function automatic logic [HASH_W-1:0] byte_rev(input logic [HASH_W-1:0] x);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int b = 0; b < HASH_W/8; b++) begin
      r[8*(HASH_W/8-1-b) +: 8] = x[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hash_compare_pipe_compare_lane.sv
// compare_lane
//   One hash lane of the two-stage compare pipeline.
//   Stage 1 registers h0 = IV ^ v0 ^ v8 plus the target and compare sense;
//   stage 2 registers the byte-reversed hash and its hit bit. Validity is
//   tracked once for all lanes in the top level.
// Ports
//   clk, rst          clock, async active-low reset
//   v0, v8            final state words of this lane
//   target, le_mode   difficulty target; le_mode=1 means hash <= target
//   hit               stage-2 hit bit (unqualified by valid)
//   hash              stage-2 byte-reversed hash
module compare_lane
  import hash_compare_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [HASH_W-1:0] v0,
  input  logic [HASH_W-1:0] v8,
  input  logic [HASH_W-1:0] target,
  input  logic              le_mode,
  output logic              hit,
  output logic [HASH_W-1:0] hash
);

  logic [HASH_W-1:0] h0_s1;
  logic [HASH_W-1:0] tgt_s1;
  logic              le_s1;
  logic [HASH_W-1:0] hash_c;
  logic              hit_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h0_s1  <= '0;
      tgt_s1 <= '0;
      le_s1  <= 1'b0;
    end else begin
      h0_s1  <= IV ^ v0 ^ v8;
      tgt_s1 <= target;
      le_s1  <= le_mode;
    end
  end

  always_comb begin
    hash_c = byte_rev(h0_s1);
    hit_c  = le_s1 ? (hash_c <= tgt_s1) : (hash_c < tgt_s1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit  <= 1'b0;
      hash <= '0;
    end else begin
      hit  <= hit_c;
      hash <= hash_c;
    end
  end

endmodule

// File: rtl/hash_compare_pipe.sv
// hash_compare_pipe
//   Checks LANES hashes per beat against a target in a 2-stage pipeline
//   (in_valid in cycle N -> done in cycle N+2, one beat per cycle), holds
//   the first unacknowledged hit, and counts checked beats and hit beats.
// Ports
//   clk, rst               clock, async active-low reset
//   clr                    synchronous clear of valids, hit register, counters, overflow
//   in_valid, v0, v8       beat of LANES lanes, lane i at bits [64i+63:64i]
//   nonce_base             nonce of lane 0; lane i uses nonce_base+i
//   target, le_mode        compare target and sense, sampled with in_valid
//   done, found            per-beat result pulse and any-lane-hit flag
//   hit_valid, hit_*       held hit (lowest hitting lane), released by hit_ack
//   overflow               sticky: a hit was dropped while the register was full
//   checked_cnt, hit_cnt   wrapping beat count, saturating hit-beat count
//
// Hit register states
//   state     | meaning
//   HIT_EMPTY | no hit held, hit_valid=0; next found beat is captured
//   HIT_FULL  | hit held, hit_valid=1; new hits captured only with hit_ack
module hash_compare_pipe
  import hash_compare_pipe_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [HASH_W*LANES-1:0] v0,
  input  logic [HASH_W*LANES-1:0] v8,
  input  logic [NONCE_W-1:0]      nonce_base,
  input  logic [HASH_W-1:0]       target,
  input  logic                    le_mode,
  output logic                    done,
  output logic                    found,
  output logic                    hit_valid,
  output logic [NONCE_W-1:0]      hit_nonce,
  output logic [2:0]              hit_lane,
  output logic [HASH_W-1:0]       hit_hash,
  input  logic                    hit_ack,
  output logic                    overflow,
  output logic [CNT_W-1:0]        checked_cnt,
  output logic [15:0]             hit_cnt
);

  logic [LANES-1:0]        lane_hit;
  logic [HASH_W*LANES-1:0] lane_hash;
  logic                    valid_s1, valid_s2;
  logic [NONCE_W-1:0]      nonce_s1, nonce_s2;
  logic [2:0]              sel_lane;
  logic [HASH_W-1:0]       sel_hash;
  hit_state_t              state, state_nxt;
  logic                    capture;
  logic                    ovf_set;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    compare_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .v0      (v0[HASH_W*i +: HASH_W]),
      .v8      (v8[HASH_W*i +: HASH_W]),
      .target  (target),
      .le_mode (le_mode),
      .hit     (lane_hit[i]),
      .hash    (lane_hash[HASH_W*i +: HASH_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      nonce_s1 <= '0;
      nonce_s2 <= '0;
    end else begin
      valid_s1 <= in_valid & ~clr;
      valid_s2 <= valid_s1 & ~clr;
      nonce_s1 <= nonce_base;
      nonce_s2 <= nonce_s1;
    end
  end

  assign done  = valid_s2;
  assign found = valid_s2 & (|lane_hit);

  // Scan from the top down so the lowest hitting lane wins.
  always_comb begin
    sel_lane = '0;
    sel_hash = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (lane_hit[i]) begin
        sel_lane = 3'(i);
        sel_hash = lane_hash[HASH_W*i +: HASH_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= HIT_EMPTY;
    else if (clr) state <= HIT_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      HIT_EMPTY: begin
        if (found) begin
          state_nxt = HIT_FULL;
          capture   = 1'b1;
        end
      end
      HIT_FULL: begin
        if (hit_ack) begin
          if (found) capture   = 1'b1;
          else       state_nxt = HIT_EMPTY;
        end else if (found) begin
          ovf_set = 1'b1;
        end
      end
      default: state_nxt = HIT_EMPTY;
    endcase
  end

  assign hit_valid = (state == HIT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_nonce <= '0;
      hit_lane  <= '0;
      hit_hash  <= '0;
    end else if (capture && !clr) begin
      hit_nonce <= nonce_s2 + NONCE_W'(sel_lane);
      hit_lane  <= sel_lane;
      hit_hash  <= sel_hash;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      checked_cnt <= '0;
      hit_cnt     <= '0;
    end else if (clr) begin
      overflow    <= 1'b0;
      checked_cnt <= '0;
      hit_cnt     <= '0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (done) checked_cnt <= checked_cnt + CNT_W'(1);
      if (found && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hash_compare_pipe.sv
module tb_hash_compare_pipe;

  localparam int LANES   = 4;
  localparam int NONCE_W = 32;
  localparam int CNT_W   = 8;
  localparam logic [63:0] IV_C = 64'h6a09e667f2bdc928;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  clr = 1'b0;
  logic                  in_valid = 1'b0;
  logic [64*LANES-1:0]   v0 = '0;
  logic [64*LANES-1:0]   v8 = '0;
  logic [NONCE_W-1:0]    nonce_base = '0;
  logic [63:0]           target = '0;
  logic                  le_mode = 1'b0;
  logic                  hit_ack = 1'b0;
  logic                  done, found, hit_valid, overflow;
  logic [NONCE_W-1:0]    hit_nonce;
  logic [2:0]            hit_lane;
  logic [63:0]           hit_hash;
  logic [CNT_W-1:0]      checked_cnt;
  logic [15:0]           hit_cnt;

  int checks = 0;
  int errors = 0;

  hash_compare_pipe #(.LANES(LANES), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .v0          (v0),
    .v8          (v8),
    .nonce_base  (nonce_base),
    .target      (target),
    .le_mode     (le_mode),
    .done        (done),
    .found       (found),
    .hit_valid   (hit_valid),
    .hit_nonce   (hit_nonce),
    .hit_lane    (hit_lane),
    .hit_hash    (hit_hash),
    .hit_ack     (hit_ack),
    .overflow    (overflow),
    .checked_cnt (checked_cnt),
    .hit_cnt     (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][63:0] h;     // desired per-lane hash
    logic [31:0]      nb;
    logic [63:0]      tgt;
    logic             le;
    logic             ef;
    logic [2:0]       el;
    logic [63:0]      eh;
    logic [31:0]      en;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [63:0] swap8(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = x[8*(7-b) +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic [63:0] h0, h1, h2, h3, input logic [31:0] nb,
                              input logic [63:0] tgt, input logic le, ef, input logic [2:0] el,
                              input logic [63:0] eh, input logic [31:0] en);
    vec_t v;
    v.h[0] = h0; v.h[1] = h1; v.h[2] = h2; v.h[3] = h3;
    v.nb = nb; v.tgt = tgt; v.le = le; v.ef = ef; v.el = el; v.eh = eh; v.en = en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v0=0 and v8=IV^swap(h) make the lane's final hash equal h.
  task automatic load(input vec_t v);
    v0 = '0;
    for (int i = 0; i < LANES; i++) v8[64*i +: 64] = IV_C ^ swap8(v.h[i]);
    nonce_base = v.nb;
    target     = v.tgt;
    le_mode    = v.le;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " done"},        64'(done), 0);
    chk({tag, " found"},       64'(found), 0);
    chk({tag, " hit_valid"},   64'(hit_valid), 0);
    chk({tag, " hit_nonce"},   64'(hit_nonce), 0);
    chk({tag, " hit_lane"},    64'(hit_lane), 0);
    chk({tag, " hit_hash"},    hit_hash, 0);
    chk({tag, " overflow"},    64'(overflow), 0);
    chk({tag, " checked_cnt"}, 64'(checked_cnt), 0);
    chk({tag, " hit_cnt"},     64'(hit_cnt), 0);
  endtask

  initial begin
    int nhits;
    int ndone;
    vec_t hitv, missv;

    vecs[0] = mk(64'h0, ONES, ONES, ONES, 32'h100, 64'h1, 1'b0, 1'b1, 3'd0, 64'h0, 32'h100);
    vecs[1] = mk(ONES, ONES, 64'h1, ONES, 32'h200, 64'h1, 1'b0, 1'b0, 3'd0, 64'h0, 32'h0);
    vecs[2] = mk(ONES, ONES, 64'h1, ONES, 32'h200, 64'h1, 1'b1, 1'b1, 3'd2, 64'h1, 32'h202);
    vecs[3] = mk(ONES, 64'h5, ONES, 64'h5, 32'h300, 64'h6, 1'b0, 1'b1, 3'd1, 64'h5, 32'h301);
    vecs[4] = mk(ONES, ONES, ONES, ONES, 32'h400, ONES, 1'b1, 1'b1, 3'd0, ONES, 32'h400);
    vecs[5] = mk(64'h8000_0000_0000_0000, ONES, ONES, ONES, 32'h500,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'd0, 64'h0, 32'h0);
    vecs[6] = mk(ONES, 64'h10, ONES, ONES, 32'hFFFF_FFFF, 64'h11, 1'b0, 1'b1, 3'd1, 64'h10, 32'h0);
    vecs[7] = mk(ONES, ONES, ONES, 64'h0102_0304_0506_0708, 32'h700,
                 64'h0102_0304_0506_0709, 1'b0, 1'b1, 3'd3, 64'h0102_0304_0506_0708, 32'h703);
    vecs[8] = mk(ONES, ONES, ONES, 64'h42, 32'h800, 64'h42, 1'b0, 1'b0, 3'd0, 64'h0, 32'h0);
    hitv  = vecs[0];
    missv = vecs[1];

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    tick();

    // Table: one beat per vector, latency and hit capture checked each time
    nhits = 0;
    foreach (vecs[k]) begin
      load(vecs[k]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d done@N+1", k), 64'(done), 0);
      tick();
      chk($sformatf("v%0d done@N+2", k), 64'(done), 1);
      chk($sformatf("v%0d found", k), 64'(found), 64'(vecs[k].ef));
      tick();
      chk($sformatf("v%0d done@N+3", k), 64'(done), 0);
      chk($sformatf("v%0d found idle", k), 64'(found), 0);
      chk($sformatf("v%0d hit_valid", k), 64'(hit_valid), 64'(vecs[k].ef));
      if (vecs[k].ef) begin
        nhits++;
        chk($sformatf("v%0d hit_lane", k), 64'(hit_lane), 64'(vecs[k].el));
        chk($sformatf("v%0d hit_hash", k), hit_hash, vecs[k].eh);
        chk($sformatf("v%0d hit_nonce", k), 64'(hit_nonce), 64'(vecs[k].en));
        hit_ack = 1'b1;
        tick();
        hit_ack = 1'b0;
        chk($sformatf("v%0d ack empties", k), 64'(hit_valid), 0);
      end
      chk($sformatf("v%0d overflow", k), 64'(overflow), 0);
    end
    chk("table checked_cnt", 64'(checked_cnt), 9);
    chk("table hit_cnt", 64'(hit_cnt), 64'(nhits));

    // clr zeroes counters
    do_clr();
    chk("clr checked_cnt", 64'(checked_cnt), 0);
    chk("clr hit_cnt", 64'(hit_cnt), 0);

    // hit_ack while empty is ignored
    hit_ack = 1'b1;
    tick();
    hit_ack = 1'b0;
    chk("ack empty hit_valid", 64'(hit_valid), 0);
    chk("ack empty overflow", 64'(overflow), 0);

    // Two back-to-back hits without ack: first held, overflow set
    load(hitv);
    nonce_base = 32'd100;
    in_valid = 1'b1;
    tick();
    nonce_base = 32'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ovf hit_valid", 64'(hit_valid), 1);
    chk("ovf hit_nonce", 64'(hit_nonce), 100);
    chk("ovf overflow", 64'(overflow), 1);
    chk("ovf hit_cnt", 64'(hit_cnt), 2);
    do_clr();
    chk("clr hit_valid", 64'(hit_valid), 0);
    chk("clr overflow", 64'(overflow), 0);

    // Ack coincident with a new hit: new data captured, stays full
    load(hitv);
    nonce_base = 32'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ackhit first nonce", 64'(hit_nonce), 10);
    nonce_base = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    hit_ack = 1'b1;
    tick();
    hit_ack = 1'b0;
    chk("ackhit hit_valid", 64'(hit_valid), 1);
    chk("ackhit hit_nonce", 64'(hit_nonce), 20);
    chk("ackhit overflow", 64'(overflow), 0);

    // clr beats an in-flight beat
    do_clr();
    load(hitv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr flight done", 64'(done), 0);
    tick();
    chk("clr flight done2", 64'(done), 0);
    chk("clr flight hit_valid", 64'(hit_valid), 0);

    // checked_cnt wrap (CNT_W=8): 255 beats, then one more wraps to 0
    load(missv);
    in_valid = 1'b1;
    for (int n = 0; n < 255; n++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("wrap 255", 64'(checked_cnt), 255);
    chk("wrap hit_cnt", 64'(hit_cnt), 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("wrap to 0", 64'(checked_cnt), 0);

    // Reset with two beats in flight
    do_clr();
    load(hitv);
    nonce_base = 32'd1;
    in_valid = 1'b1;
    tick();
    nonce_base = 32'd2;
    tick();
    in_valid = 1'b0;
    chk("pre-rst done", 64'(done), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    @(negedge clk) rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (done) ndone++;
    end
    chk("post-rst done count", 64'(ndone), 0);
    chk("post-rst hit_valid", 64'(hit_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
